// File: rtl/bus_arbiter_if.sv
// Shared-bus arbiter signal bundle: CPU side, loader side and the granted bus cycle.
// master drives the requests; slave is the arbiter that answers them.
interface bus_arbiter_if;
    logic        AS;
    logic        RWb;
    logic [15:0] ADDR;
    logic        LD_REQ;
    logic        LD_WR;
    logic [15:0] LD_ADDR;
    logic [15:0] BUS_ADDR;
    logic        BUS_RWb;
    logic        BUS_AS;
    logic        DTAC;
    logic        LD_ACK;
    logic        OWNER;

    modport master (
        output AS, RWb, ADDR,
        output LD_REQ, LD_WR, LD_ADDR,
        input  BUS_ADDR, BUS_RWb, BUS_AS,
        input  DTAC, LD_ACK, OWNER
    );

    modport slave (
        input  AS, RWb, ADDR,
        input  LD_REQ, LD_WR, LD_ADDR,
        output BUS_ADDR, BUS_RWb, BUS_AS,
        output DTAC, LD_ACK, OWNER
    );
endinterface

// File: rtl/bus_arbiter.sv
// CPU / loader shared-bus arbiter with fair tie-break and address-based wait states.
// Define LOADER_ARB_EN to enable the loader path; otherwise only the CPU is served.
module bus_arbiter (
    input logic       CLK12,
    input logic       RST,
    input logic       CE,
    bus_arbiter_if.slave bus
);
    typedef enum logic [1:0] {
        IDLE,
        CPU_CYC,
        LD_CYC,
        RECOVER
    } state_t;

    state_t      state;
    logic [15:0] bus_addr;
    logic        bus_rwb;
    logic        bus_as;
    logic        dtac;
    logic        ld_ack;
    logic        owner;
    logic        last_ld;
    logic [1:0]  wait_cnt;

    logic cpu_req;
    logic ld_req;
    logic pick_cpu;
    logic pick_ld;

    function automatic logic [1:0] waits(input logic [15:0] a);
        logic [1:0] w;
        unique case (1'b1)
            (a[15:14] == 2'b01):  w = 2'd2;
            (a[15:13] == 3'b000): w = 2'd0;
            default:              w = 2'd1;
        endcase
        return w;
    endfunction

`ifdef LOADER_ARB_EN
    assign ld_req = bus.LD_REQ;
`else
    assign ld_req = 1'b0;
    wire unused_ld_req = bus.LD_REQ;
`endif

    assign cpu_req  = CE & ~bus.AS;
    // Ties go to whoever was not served last.
    assign pick_cpu = cpu_req & (~ld_req | last_ld);
    assign pick_ld  = ld_req & ~pick_cpu;

    always_ff @(posedge CLK12) begin
        if (RST) begin
            state    <= IDLE;
            bus_addr <= 16'hFFFF;
            bus_rwb  <= 1'b1;
            bus_as   <= 1'b1;
            dtac     <= 1'b1;
            ld_ack   <= 1'b0;
            owner    <= 1'b0;
            last_ld  <= 1'b1;
            wait_cnt <= 2'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (pick_cpu) begin
                        state    <= CPU_CYC;
                        bus_addr <= bus.ADDR;
                        bus_rwb  <= bus.RWb;
                        bus_as   <= 1'b0;
                        wait_cnt <= waits(bus.ADDR);
                        owner    <= 1'b0;
                        last_ld  <= 1'b0;
                    end else if (pick_ld) begin
                        state    <= LD_CYC;
                        bus_addr <= bus.LD_ADDR;
                        bus_rwb  <= ~bus.LD_WR;
                        bus_as   <= 1'b0;
                        wait_cnt <= waits(bus.LD_ADDR);
                        owner    <= 1'b1;
                        last_ld  <= 1'b1;
                    end
                end
                CPU_CYC: begin
                    if (CE) begin
                        // A released strobe ends the cycle whether or not DTAC went out.
                        if (bus.AS) begin
                            state  <= RECOVER;
                            bus_as <= 1'b1;
                            dtac   <= 1'b1;
                        end else if (wait_cnt <= 2'd1) begin
                            dtac     <= 1'b0;
                            wait_cnt <= 2'd0;
                        end else begin
                            wait_cnt <= wait_cnt - 2'd1;
                        end
                    end
                end
                LD_CYC: begin
                    if (wait_cnt == 2'd0) begin
                        state  <= RECOVER;
                        bus_as <= 1'b1;
                        ld_ack <= 1'b1;
                    end else begin
                        wait_cnt <= wait_cnt - 2'd1;
                    end
                end
                RECOVER: begin
                    ld_ack <= 1'b0;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.BUS_ADDR = bus_addr;
    assign bus.BUS_RWb  = bus_rwb;
    assign bus.BUS_AS   = bus_as;
    assign bus.DTAC     = dtac;
    assign bus.LD_ACK   = ld_ack;
    assign bus.OWNER    = owner;
endmodule

// File: tb/tb_bus_arbiter.sv
// Self-checking bench for bus_arbiter: directed scenarios plus randomized accesses.
// Loader checks are compiled in only when LOADER_ARB_EN is defined.
module tb_bus_arbiter;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic ce  = 1'b0;
    int   phase = 0;
    logic ce_was = 1'b0;
    int   passed = 0;
    int   failed = 0;
    int   total = 0;

    bus_arbiter_if bif ();

    bus_arbiter dut (
        .CLK12(clk),
        .RST  (rst),
        .CE   (ce),
        .bus  (bif)
    );

    always #5 clk = ~clk;

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic int exp_waits(input int a);
        if (a >= 'h4000 && a <= 'h7FFF) return 2;
        else if (a <= 'h1FFF) return 0;
        else return 1;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) passed++;
        else begin
            failed++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
        end
    endtask

    // One CLK12 cycle: outputs of the last edge are visible, CE set for the next edge.
    task automatic step();
        @(negedge clk);
        ce_was = ce;
        phase  = (phase + 1) % 8;
        ce     = (phase == 0);
    endtask

    task automatic chk_reset(input string tag);
        chk({tag, "_bus_as"}, bif.BUS_AS, 1);
        chk({tag, "_dtac"}, bif.DTAC, 1);
        chk({tag, "_ld_ack"}, bif.LD_ACK, 0);
        chk({tag, "_owner"}, bif.OWNER, 0);
        chk({tag, "_rwb"}, bif.BUS_RWb, 1);
        chk({tag, "_addr"}, bif.BUS_ADDR, 16'hFFFF);
    endtask

    task automatic cpu_start(input logic [15:0] a, input logic rw, input bit with_ld);
        int n;
        n = 0;
        while (ce !== 1'b1 && n < 16) begin
            step();
            n++;
        end
        bif.AS = 1'b0;
        bif.ADDR = a;
        bif.RWb = rw;
        if (with_ld) begin
            bif.LD_REQ = 1'b1;
            bif.LD_ADDR = 16'h8000;
            bif.LD_WR = 1'b1;
        end
        step();
        chk("grant_bus_as", bif.BUS_AS, 0);
        chk("grant_addr", bif.BUS_ADDR, a);
        chk("grant_rwb", bif.BUS_RWb, rw);
        chk("grant_owner", bif.OWNER, 0);
        chk("grant_dtac", bif.DTAC, 1);
        chk("grant_ld_ack", bif.LD_ACK, 0);
    endtask

    task automatic cpu_finish(input logic [15:0] a);
        int w, n, edges;
        bit seen, early;
        w = exp_waits(a);
        n = 0;
        edges = 0;
        seen = 0;
        while (!seen && n < 64) begin
            step();
            n++;
            if (ce_was) edges++;
            if (bif.DTAC === 1'b0) seen = 1;
        end
        chk("dtac_seen", seen, 1);
        chk("dtac_ce_edges", edges, (w < 1) ? 1 : w);
        chk("hold_addr", bif.BUS_ADDR, a);
        chk("hold_bus_as", bif.BUS_AS, 0);
        step();
        chk("dtac_hold", bif.DTAC, 0);
        bif.AS = 1'b1;
        early = 0;
        n = 0;
        do begin
            step();
            n++;
            if (!ce_was && bif.DTAC !== 1'b0) early = 1;
        end while (!ce_was && n < 16);
        chk("dtac_early_release", early, 0);
        chk("recover_dtac", bif.DTAC, 1);
        chk("recover_bus_as", bif.BUS_AS, 1);
    endtask

    task automatic cpu_access(input logic [15:0] a, input logic rw, input bit abort);
        int n;
        bit dt;
        cpu_start(a, rw, 0);
        if (abort) begin
            n = 0;
            dt = 0;
            while (ce !== 1'b1 && n < 16) begin
                step();
                n++;
                if (bif.DTAC !== 1'b1) dt = 1;
            end
            bif.AS = 1'b1;
            step();
            chk("abort_no_dtac", dt | (bif.DTAC !== 1'b1), 0);
            chk("abort_bus_as", bif.BUS_AS, 1);
        end else begin
            cpu_finish(a);
        end
        step();
        chk("idle_bus_as", bif.BUS_AS, 1);
        chk("idle_dtac", bif.DTAC, 1);
    endtask

`ifdef LOADER_ARB_EN
    task automatic ld_access(input logic [15:0] a, input logic wr);
        int w, n;
        bit seen;
        w = exp_waits(a);
        bif.LD_REQ = 1'b1;
        bif.LD_ADDR = a;
        bif.LD_WR = wr;
        step();
        chk("ld_owner", bif.OWNER, 1);
        chk("ld_bus_as", bif.BUS_AS, 0);
        chk("ld_addr", bif.BUS_ADDR, a);
        chk("ld_rwb", bif.BUS_RWb, !wr);
        bif.LD_REQ = 1'b0;
        n = 0;
        seen = 0;
        while (!seen && n < 8) begin
            step();
            n++;
            if (bif.LD_ACK === 1'b1) seen = 1;
        end
        chk("ld_ack_seen", seen, 1);
        chk("ld_latency", n + 1, w + 2);
        chk("ld_recover_as", bif.BUS_AS, 1);
        step();
        chk("ld_ack_width", bif.LD_ACK, 0);
        chk("ld_idle_as", bif.BUS_AS, 1);
        chk("ld_owner_hold", bif.OWNER, 1);
    endtask
`endif

    initial begin
        logic [15:0] edge_addrs [6];
        logic [15:0] a16;
        logic        rw;
        int          kind;

        bif.AS = 1'b1;
        bif.RWb = 1'b1;
        bif.ADDR = 16'h0000;
        bif.LD_WR = 1'b0;
        bif.LD_ADDR = 16'h0000;
`ifdef LOADER_ARB_EN
        bif.LD_REQ = 1'b0;
`else
        bif.LD_REQ = 1'b1;
`endif
        rst = 1'b1;
        repeat (3) step();
        chk_reset("rst_init");
        rst = 1'b0;

        cpu_start(16'h4000, 1'b1, 1'b1);
        cpu_finish(16'h4000);
        step();
        chk("tie_idle_as", bif.BUS_AS, 1);
        step();
`ifdef LOADER_ARB_EN
        chk("tie_ld_owner", bif.OWNER, 1);
        chk("tie_ld_addr", bif.BUS_ADDR, 16'h8000);
        chk("tie_ld_bus_as", bif.BUS_AS, 0);
        chk("tie_ld_rwb", bif.BUS_RWb, 0);
        bif.LD_REQ = 1'b0;
        step();
        chk("tie_ld_wait", bif.LD_ACK, 0);
        step();
        chk("tie_ld_ack", bif.LD_ACK, 1);
        step();
        chk("tie_ld_ack_width", bif.LD_ACK, 0);
        chk("tie_ld_recover", bif.BUS_AS, 1);
`else
        chk("nold_owner", bif.OWNER, 0);
        chk("nold_bus_as", bif.BUS_AS, 1);
        chk("nold_ld_ack", bif.LD_ACK, 0);
`endif

        cpu_access(16'h4000, 1'b1, 0);
        cpu_access(16'h0100, 1'b0, 0);
        cpu_access(16'h5000, 1'b1, 1);
        edge_addrs = '{16'h1FFF, 16'h2000, 16'h3FFF, 16'h7FFF, 16'h8000, 16'hFFFF};
        foreach (edge_addrs[i]) cpu_access(edge_addrs[i], i[0], 0);

        cpu_start(16'h4000, 1'b1, 0);
        rst = 1'b1;
        step();
        chk_reset("rst_cpu");
        bif.AS = 1'b1;
        rst = 1'b0;
        step();
        chk("post_rst_cpu_dtac", bif.DTAC, 1);
        chk("post_rst_cpu_as", bif.BUS_AS, 1);

`ifdef LOADER_ARB_EN
        ld_access(16'h0000, 1'b1);
        ld_access(16'h8000, 1'b0);
        ld_access(16'h4000, 1'b1);
        bif.LD_REQ = 1'b1;
        bif.LD_ADDR = 16'h4000;
        bif.LD_WR = 1'b0;
        step();
        chk("rst_ld_owner", bif.OWNER, 1);
        bif.LD_REQ = 1'b0;
        step();
        chk("rst_ld_pre", bif.LD_ACK, 0);
        rst = 1'b1;
        step();
        chk_reset("rst_ld");
        rst = 1'b0;
        step();
        chk("rst_ld_after", bif.LD_ACK, 0);
        chk("rst_ld_as", bif.BUS_AS, 1);
        step();
        chk("rst_ld_after2", bif.LD_ACK, 0);
`endif

        for (int it = 0; it < 24; it++) begin
            a16 = 16'($urandom_range(0, 65535));
            rw = 1'($urandom_range(0, 1));
            kind = $urandom_range(0, 3);
`ifdef LOADER_ARB_EN
            if (kind == 0) ld_access(a16, rw);
            else
`endif
            cpu_access(a16, rw, kind == 1);
        end

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
